// File: rtl/neural_unit_sequencer.sv
// neural_unit_sequencer: streams four weights into the neural unit, fires its summer and captures the layer result.
// Defining SEQ_TIMEOUT_EN adds a WAIT watchdog that drives the sticky error flag.
module neural_unit_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        layer_sel_in,
    input  logic [7:0]  w_data,
    input  logic        w_valid,
    output logic        w_ready,
    output logic [7:0]  weight,
    output logic [1:0]  address,
    output logic        write,
    output logic        sumTrigger,
    output logic        layer_Sel,
    input  logic [31:0] layerOut,
    input  logic        layerDone,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, FIRE, WAIT, HOLD} state_t;

    state_t     state, nextState;
    logic [1:0] wCnt;
    logic [3:0] settleCnt;
    logic       beat;
    logic       timeout;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gBadSettle
        $error("SETTLE_CYCLES must be within 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign beat = (state == LOAD) && w_valid && w_ready;

`ifdef SEQ_TIMEOUT_EN
    localparam int WaitW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WaitW-1:0] waitCnt;

    // layerDone outranks the watchdog when both land in the same cycle
    assign timeout = (state == WAIT) && !layerDone && (waitCnt == WaitW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waitCnt <= '0;
            error   <= 1'b0;
        end else begin
            waitCnt <= (state == WAIT) ? waitCnt + 1'b1 : '0;
            if (state == IDLE && start)
                error <= 1'b0;
            else if (timeout)
                error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = start ? LOAD : IDLE;
            LOAD:    nextState = (beat && wCnt == 2'd3) ? SETTLE : LOAD;
            SETTLE:  nextState = (settleCnt == 4'(SETTLE_CYCLES - 1)) ? FIRE : SETTLE;
            FIRE:    nextState = WAIT;
            WAIT:    nextState = layerDone ? HOLD : (timeout ? IDLE : WAIT);
            HOLD:    nextState = result_ready ? IDLE : HOLD;
            default: nextState = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wCnt         <= 2'd0;
            settleCnt    <= 4'd0;
            w_ready      <= 1'b0;
            weight       <= 8'd0;
            address      <= 2'd0;
            write        <= 1'b0;
            sumTrigger   <= 1'b0;
            layer_Sel    <= 1'b0;
            result       <= 32'd0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= nextState;
            w_ready      <= nextState == LOAD;
            sumTrigger   <= nextState == FIRE;
            result_valid <= nextState == HOLD;
            busy         <= nextState != IDLE;
            write        <= beat;
            settleCnt    <= (state == SETTLE) ? settleCnt + 1'b1 : 4'd0;
            if (state == IDLE && start) begin
                layer_Sel <= layer_sel_in;
                wCnt      <= 2'd0;
            end
            if (beat) begin
                weight  <= w_data;
                address <= wCnt;
                wCnt    <= wCnt + 1'b1;
            end
            if (state == WAIT && layerDone)
                result <= layerOut;
        end
    end
endmodule
